// File: rtl/easyaxi_ost_alloc_pkg.sv
// rtl/easyaxi_ost_alloc_pkg.sv - shared defaults and types for the outstanding-slot allocator
package easyaxi_ost_alloc_pkg;

    localparam int OST_DEPTH_DEF  = 16;
    localparam int ID_WIDTH_DEF   = 4;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF  = 8;

    // Classification of the response beat seen in the current cycle.
    typedef enum logic [1:0] {
        BEAT_NONE,
        BEAT_MID,
        BEAT_LAST,
        BEAT_STRAY
    } beat_kind_e;

endpackage

// File: rtl/easyaxi_prio_enc.sv
// rtl/easyaxi_prio_enc.sv - lowest-set-bit priority encoder with found flag
module easyaxi_prio_enc
    import easyaxi_ost_alloc_pkg::*;
#(
    parameter int WIDTH     = OST_DEPTH_DEF,
    parameter int IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     vec,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 found
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/easyaxi_ost_alloc.sv
// rtl/easyaxi_ost_alloc.sv - outstanding-slot allocator in front of the AXI request channel
module easyaxi_ost_alloc
    import easyaxi_ost_alloc_pkg::*;
#(
    parameter int OST_DEPTH  = OST_DEPTH_DEF,
    parameter int ID_WIDTH   = ID_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ID_WIDTH-1:0]          in_id,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [LEN_WIDTH-1:0]         in_len,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [ID_WIDTH-1:0]          req_id,
    output logic [ADDR_WIDTH-1:0]        req_addr,
    output logic [LEN_WIDTH-1:0]         req_len,
    output logic [$clog2(OST_DEPTH)-1:0] req_ptr,
    input  logic                         resp_valid,
    input  logic                         resp_ready,
    input  logic                         resp_last,
    input  logic [$clog2(OST_DEPTH)-1:0] resp_ptr,
    output logic [$clog2(OST_DEPTH):0]   ost_cnt,
    output logic                         ost_full,
    output logic                         len_err,
    output logic                         free_err
);

    localparam int PTR_WIDTH = $clog2(OST_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(OST_DEPTH);

    logic [OST_DEPTH-1:0] busy;
    logic [LEN_WIDTH-1:0] slot_len [OST_DEPTH];
    logic [LEN_WIDTH:0]   beat_cnt [OST_DEPTH];

    logic [PTR_WIDTH-1:0] free_idx;
    logic                 free_found;
    logic                 alloc;
    logic                 release_slot;
    logic                 beat_len_err;
    logic                 len_match;
    logic [CNT_WIDTH-1:0] cnt_next;
    beat_kind_e           beat_kind;

    easyaxi_prio_enc #(
        .WIDTH     (OST_DEPTH),
        .IDX_WIDTH (PTR_WIDTH)
    ) u_free_enc (
        .vec   (~busy),
        .idx   (free_idx),
        .found (free_found)
    );

    assign in_ready = ~ost_full & free_found & (~req_valid | req_ready);
    assign alloc    = in_valid & in_ready;

    always_comb begin
        beat_kind = BEAT_NONE;
        if (resp_valid && resp_ready) begin
            if (!busy[resp_ptr]) begin
                beat_kind = BEAT_STRAY;
            end else if (resp_last) begin
                beat_kind = BEAT_LAST;
            end else begin
                beat_kind = BEAT_MID;
            end
        end
    end

    // A mid beat arriving once the count already equals LEN overruns the burst;
    // a last beat must land exactly on LEN.
    assign len_match    = (beat_cnt[resp_ptr] == {1'b0, slot_len[resp_ptr]});
    assign beat_len_err = ((beat_kind == BEAT_MID) && len_match) ||
                          ((beat_kind == BEAT_LAST) && !len_match);
    assign release_slot = (beat_kind == BEAT_LAST);

    always_comb begin
        cnt_next = ost_cnt;
        if (alloc && !release_slot) begin
            cnt_next = ost_cnt + 1'b1;
        end else if (!alloc && release_slot) begin
            cnt_next = ost_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            for (int i = 0; i < OST_DEPTH; i++) begin
                slot_len[i] <= '0;
                beat_cnt[i] <= '0;
            end
            req_valid <= 1'b0;
            req_id    <= '0;
            req_addr  <= '0;
            req_len   <= '0;
            req_ptr   <= '0;
            ost_cnt   <= '0;
            ost_full  <= 1'b0;
            len_err   <= 1'b0;
            free_err  <= 1'b0;
        end else begin
            len_err  <= beat_len_err;
            free_err <= (beat_kind == BEAT_STRAY);
            ost_cnt  <= cnt_next;
            ost_full <= (cnt_next == FULL_CNT);

            case (beat_kind)
                BEAT_MID: beat_cnt[resp_ptr] <= beat_cnt[resp_ptr] + 1'b1;
                BEAT_LAST: begin
                    busy[resp_ptr]     <= 1'b0;
                    beat_cnt[resp_ptr] <= '0;
                end
                default: ;
            endcase

            // The allocated slot is never busy, so it cannot collide with the beat update.
            if (alloc) begin
                busy[free_idx]     <= 1'b1;
                slot_len[free_idx] <= in_len;
                beat_cnt[free_idx] <= '0;
                req_valid          <= 1'b1;
                req_id             <= in_id;
                req_addr           <= in_addr;
                req_len            <= in_len;
                req_ptr            <= free_idx;
            end else if (req_valid && req_ready) begin
                req_valid <= 1'b0;
            end
        end
    end

endmodule
